// File: rtl/conv3x3_stream_if.sv
// Stream/coefficient bundle for conv3x3_stream: pixel input, coefficient load and result output.
interface conv3x3_stream_if #(
   parameter int unsigned DW    = 16,
   parameter int unsigned CW    = 16,
   parameter int unsigned OUT_W = 32
);
   logic                    rdata_r;
   logic signed [DW-1:0]    data_in;
   logic                    coef_we;
   logic [3:0]              coef_addr;
   logic signed [CW-1:0]    coef_data;
   logic signed [OUT_W-1:0] data_out;
   logic                    wdata_r;
   logic                    sat;
   logic                    frame_done;

   modport master (
      output rdata_r, data_in, coef_we, coef_addr, coef_data,
      input  data_out, wdata_r, sat, frame_done
   );

   modport slave (
      input  rdata_r, data_in, coef_we, coef_addr, coef_data,
      output data_out, wdata_r, sat, frame_done
   );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 "valid"-mode convolution with two line buffers, frame-synchronous kernel
// commit, arithmetic scaling and output saturation. Fixed 2-cycle accept-to-result latency.
module conv3x3_stream #(
   parameter int unsigned DW    = 16,
   parameter int unsigned CW    = 16,
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28,
   parameter int unsigned SHIFT = 0,
   parameter int unsigned OUT_W = 32
) (
   input logic             clk,
   input logic             reset_n,
   conv3x3_stream_if.slave bus
);
   localparam int unsigned NTAP  = 9;
   localparam int unsigned PW    = DW + CW;
   localparam int unsigned ACC_W = DW + CW + 4;
   localparam int unsigned EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam int          DEF_K [NTAP] = '{-4972, -622, 2988, -2478, 1703, 2519, 2008, 1748, 79};

   localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'($signed({1'b1, {(OUT_W-1){1'b0}}}));

   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic                    first_px;
   logic                    last_col;
   logic                    last_px;
   logic                    win_done;

   logic signed [CW-1:0]    shadow [NTAP];
   logic signed [CW-1:0]    active [NTAP];

   logic signed [DW-1:0]    lb0 [IMG_W];
   logic signed [DW-1:0]    lb1 [IMG_W];
   logic signed [DW-1:0]    win [NTAP];
   logic signed [PW-1:0]    prod [NTAP];

   logic                    v0, l0, v1, l1;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sh;
   logic signed [EXT_W-1:0] acc_ext;
   logic                    clip_hi;
   logic                    clip_lo;
   logic signed [OUT_W-1:0] res;

   // Position decode of the pixel currently presented.
   always_comb begin
      first_px = (row == '0) && (col == '0);
      last_col = (col == COL_W'(IMG_W - 1));
      last_px  = last_col && (row == ROW_W'(IMG_H - 1));
      win_done = (row >= ROW_W'(2)) && (col >= COL_W'(2));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col <= '0;
         row <= '0;
      end else if (bus.rdata_r) begin
         if (last_col) begin
            col <= '0;
            row <= last_px ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Shadow takes writes any time; active only reloads on the (0,0) accept, including a same-cycle write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NTAP; i++) begin
            shadow[i] <= CW'(DEF_K[i]);
            active[i] <= CW'(DEF_K[i]);
         end
      end else begin
         for (int i = 0; i < NTAP; i++) begin
            if (bus.coef_we && (bus.coef_addr == 4'(i)))
               shadow[i] <= bus.coef_data;
            if (bus.rdata_r && first_px)
               active[i] <= (bus.coef_we && (bus.coef_addr == 4'(i))) ? bus.coef_data : shadow[i];
         end
      end
   end

   // lb0 holds row y-2, lb1 row y-1; the window shifts left by one column per accepted pixel.
   always_ff @(posedge clk) begin
      if (bus.rdata_r) begin
         lb0[col] <= lb1[col];
         lb1[col] <= bus.data_in;
         win[0]   <= win[1];
         win[1]   <= win[2];
         win[2]   <= lb0[col];
         win[3]   <= win[4];
         win[4]   <= win[5];
         win[5]   <= lb1[col];
         win[6]   <= win[7];
         win[7]   <= win[8];
         win[8]   <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v0 <= 1'b0;
         l0 <= 1'b0;
         v1 <= 1'b0;
         l1 <= 1'b0;
      end else begin
         v0 <= bus.rdata_r && win_done;
         l0 <= bus.rdata_r && last_px;
         v1 <= v0;
         l1 <= l0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NTAP; i++)
         prod[i] <= PW'(win[i]) * PW'(active[i]);
   end

   // Sum, floor-shift and clip to the output range.
   always_comb begin
      acc = '0;
      for (int i = 0; i < NTAP; i++)
         acc = acc + ACC_W'(prod[i]);
      acc_sh  = acc >>> SHIFT;
      acc_ext = EXT_W'(acc_sh);
      clip_hi = acc_ext > MAX_V;
      clip_lo = acc_ext < MIN_V;
      if (clip_hi)
         res = OUT_W'(MAX_V);
      else if (clip_lo)
         res = OUT_W'(MIN_V);
      else
         res = OUT_W'(acc_ext);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.data_out   <= '0;
         bus.wdata_r    <= 1'b0;
         bus.sat        <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.wdata_r    <= v1;
         bus.sat        <= v1 && (clip_hi || clip_lo);
         bus.frame_done <= v1 && l1;
         if (v1)
            bus.data_out <= res;
      end
   end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised self-checking bench for conv3x3_stream against a direct 3x3 sum-of-products frame model.
module tb_conv3x3_stream;
   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int SHIFT = 0;
   localparam int OUT_W = 32;
   localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);

   typedef struct {
      longint val;
      bit     sat;
      bit     last;
      longint t;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;

   conv3x3_stream_if #(.DW(16), .CW(16), .OUT_W(OUT_W)) bus ();

   conv3x3_stream #(
      .DW(16), .CW(16), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(SHIFT), .OUT_W(OUT_W)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int   DEF_K [9] = '{-4972, -622, 2988, -2478, 1703, 2519, 2008, 1748, 79};
   int   ID_K  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
   int   sh_m  [9];
   int   act_m [9];
   int   img   [IMG_H][IMG_W];
   int   mr, mc;
   int   res_in_frame;
   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic void model_reset();
      sh_m  = DEF_K;
      act_m = DEF_K;
      mr    = 0;
      mc    = 0;
      exp_q.delete();
      res_in_frame = 0;
   endfunction

   // Reference: result(y,x) = sum w[3r+c]*p[y+r][x+c], floor shift, clip; due 2 edges after accept.
   function automatic void model_accept(input int p, input longint t);
      longint acc;
      longint maxv;
      longint minv;
      exp_t   e;
      if (mr == 0 && mc == 0) act_m = sh_m;
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
         acc = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               acc += longint'(act_m[3*r+c]) * longint'(img[mr-2+r][mc-2+c]);
         acc  = acc >>> SHIFT;
         maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
         minv = -(longint'(1) <<< (OUT_W - 1));
         e.sat  = (acc > maxv) || (acc < minv);
         e.val  = (acc > maxv) ? maxv : (acc < minv) ? minv : acc;
         e.last = (mr == IMG_H - 1) && (mc == IMG_W - 1);
         e.t    = t + 25;
         exp_q.push_back(e);
      end
      if (mc == IMG_W - 1) begin
         mc = 0;
         mr = (mr == IMG_H - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endfunction

   // One clock: present inputs, model the edge, then drop strobes.
   task automatic step(input bit v, input int p, input bit we, input int a, input int d);
      bus.rdata_r   = v;
      bus.data_in   = 16'(p);
      bus.coef_we   = we;
      bus.coef_addr = 4'(a);
      bus.coef_data = 16'(d);
      @(posedge clk);
      if (we && a < 9) sh_m[a] = d;
      if (v) model_accept(p, longint'($time));
      #1;
      bus.rdata_r = 1'b0;
      bus.coef_we = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_data_out", longint'(bus.data_out), 0);
      check("rst_wdata_r", longint'(bus.wdata_r), 0);
      check("rst_sat", longint'(bus.sat), 0);
      check("rst_frame_done", longint'(bus.frame_done), 0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic load_kernel(input int k [9]);
      for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1, i, k[i]);
      step(1'b0, 0, 1'b1, 9, 12345);
   endtask

   // kind: 0 ramp, 1 constant, 2 random pixels.
   task automatic run_frame(input int kind, input int cval, input int gap, input int wr_at,
                            input int rst_at, input bit we00);
      for (int i = 0; i < IMG_W * IMG_H; i++) begin
         int p;
         if (i == rst_at) begin
            do_reset();
            return;
         end
         if (i == wr_at) load_kernel(ID_K);
         while (gap > 0 && int'($urandom_range(99)) < gap) step(1'b0, 0, 1'b0, 0, 0);
         case (kind)
            0:       p = i;
            1:       p = cval;
            default: p = int'($urandom_range(65535)) - 32768;
         endcase
         if (i == 0 && we00) step(1'b1, p, 1'b1, 4, -1234);
         else                step(1'b1, p, 1'b0, 0, 0);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.wdata_r) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               res_in_frame++;
               check("data_out", longint'(bus.data_out), e.val);
               check("sat", longint'(bus.sat), longint'(e.sat));
               check("frame_done", longint'(bus.frame_done), longint'(e.last));
               check("latency", longint'($time), e.t);
               if (bus.frame_done) begin
                  check("results_per_frame", longint'(res_in_frame), longint'(NRES));
                  res_in_frame = 0;
               end
            end
         end else begin
            if (bus.frame_done) check("orphan_frame_done", 1, 0);
            if (bus.sat)        check("orphan_sat", 1, 0);
         end
      end
   end

   initial begin
      int rk [9];
      int k_pos [9];
      int k_neg [9];
      reset_n       = 1'b1;
      bus.rdata_r   = 1'b0;
      bus.data_in   = '0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      model_reset();
      #2;
      do_reset();

      // Default kernel on a flat frame, then identity on a ramp, then ramp with gaps.
      run_frame(1, 1, 0, -1, -1, 1'b0);
      load_kernel(ID_K);
      run_frame(0, 0, 0, -1, -1, 1'b0);
      run_frame(0, 0, 50, -1, -1, 1'b0);

      // Positive and negative saturation.
      for (int i = 0; i < 9; i++) begin
         k_pos[i] = 32767;
         k_neg[i] = -32768;
      end
      load_kernel(k_pos);
      run_frame(1, 32767, 0, -1, -1, 1'b0);
      load_kernel(k_neg);
      run_frame(1, 32767, 0, -1, -1, 1'b0);

      // Mid-frame kernel write only takes effect on the following frame.
      load_kernel(DEF_K);
      run_frame(0, 0, 0, 300, -1, 1'b0);
      run_frame(0, 0, 0, -1, -1, 1'b0);

      // Random kernel and pixels with gaps, plus a write coinciding with the (0,0) accept.
      for (int i = 0; i < 9; i++) rk[i] = int'($urandom_range(65535)) - 32768;
      load_kernel(rk);
      run_frame(2, 0, 30, -1, -1, 1'b1);
      run_frame(2, 0, 0, -1, -1, 1'b0);

      // Reset mid-frame restores the default kernel and restarts at (0,0).
      load_kernel(ID_K);
      run_frame(1, 1, 0, -1, 400, 1'b0);
      run_frame(1, 1, 0, -1, -1, 1'b0);

      repeat (5) step(1'b0, 0, 1'b0, 0, 0);
      check("drain_pending", longint'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
